// File: rtl/data_types.sv
// Shared data types for the result-broadcast path: tags, data words and the
// common data bus payload.
package data_types;

  localparam int CDB_NUM_SRC = 4;

  typedef logic [31:0] word32_t;
  typedef logic [4:0]  rs_tag_t;

  // Tag value meaning "nothing on the bus" / "no producer".
  localparam rs_tag_t NO_VAL = 5'd0;

  typedef struct packed {
    rs_tag_t tag;
    word32_t val;
  } cdb_t;

endpackage

// File: rtl/cdb_rr_arbiter.sv
// One-hot grant generator for the CDB result entries.
// Build option CDB_RR_ARB_EN: round-robin search starting at a pointer that
// moves to one past the last winner. Without it, lowest index wins and the
// block is purely combinational.
module cdb_rr_arbiter
  import data_types::*;
#(
  parameter int NUM_SRC = CDB_NUM_SRC
) (
`ifdef CDB_RR_ARB_EN
  input  logic               clk_i,
  input  logic               reset_ni,
`endif
  input  logic [NUM_SRC-1:0] req_i,
  output logic [NUM_SRC-1:0] gnt_o
);

`ifdef CDB_RR_ARB_EN
  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] gnt_idx;
  logic             found;

  // Pick the first requester at or after the pointer, wrapping around.
  always_comb begin
    gnt_o   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx    = PTR_W'(idx);
      end
    end
  end

  // Advance the pointer past the winner; hold it when nobody is granted.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ptr_q <= '0;
    end else if (found) begin
      ptr_q <= (gnt_idx == PTR_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`else
  logic found;

  // Lowest-index requester wins.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one buffered result per functional unit, one
// broadcast per cycle on a registered bus. Speculative results are dropped
// on a mispredict and promoted to non-speculative on a correct prediction.
// Build option CDB_RR_ARB_EN selects round-robin instead of fixed priority.
module cdb_arbiter
  import data_types::*;
#(
  parameter int NUM_SRC = CDB_NUM_SRC
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [NUM_SRC-1:0] src_valid_i,
  input  rs_tag_t            src_tag_i  [NUM_SRC],
  input  word32_t            src_val_i  [NUM_SRC],
  input  logic [NUM_SRC-1:0] src_spec_i,
  output logic [NUM_SRC-1:0] src_ready_o,
  input  logic               cond_eval_i,
  input  logic               corr_pred_i,
  output cdb_t               cdb_o
);

  logic [NUM_SRC-1:0] ent_valid;
  logic [NUM_SRC-1:0] ent_spec;
  rs_tag_t            ent_tag [NUM_SRC];
  word32_t            ent_val [NUM_SRC];

  logic               squash;
  logic               commit;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] store;
  cdb_t               cdb_nxt;

  assign squash = cond_eval_i & ~corr_pred_i;
  assign commit = cond_eval_i & corr_pred_i;

  // Entries being squashed this cycle must not reach the bus.
  assign req         = ent_valid & ~(ent_spec & {NUM_SRC{squash}});
  assign src_ready_o = ~ent_valid | grant;

  cdb_rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
`ifdef CDB_RR_ARB_EN
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
`endif
    .req_i    (req),
    .gnt_o    (grant)
  );

  // Accepted results are stored unless they carry no tag or die in a squash.
  always_comb begin
    store = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      store[i] = src_valid_i[i] & src_ready_o[i] & (src_tag_i[i] != NO_VAL)
               & ~(squash & src_spec_i[i]);
    end
  end

  // Entry bookkeeping: refill wins over drain/squash, commit clears spec.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ent_valid <= '0;
      ent_spec  <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        ent_tag[i] <= NO_VAL;
        ent_val[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (store[i]) begin
          ent_valid[i] <= 1'b1;
          ent_spec[i]  <= src_spec_i[i] & ~commit;
          ent_tag[i]   <= src_tag_i[i];
          ent_val[i]   <= src_val_i[i];
        end else begin
          if (grant[i] || (squash && ent_spec[i])) ent_valid[i] <= 1'b0;
          if (commit) ent_spec[i] <= 1'b0;
        end
      end
    end
  end

  // Select the granted entry, or an idle bus word.
  always_comb begin
    cdb_nxt.tag = NO_VAL;
    cdb_nxt.val = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        cdb_nxt.tag = ent_tag[i];
        cdb_nxt.val = ent_val[i];
      end
    end
  end

  // Register the broadcast.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cdb_o.tag <= NO_VAL;
      cdb_o.val <= '0;
    end else begin
      cdb_o <= cdb_nxt;
    end
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default CDB_NUM_SRC (4), giving the number of functional-unit result sources.
REQ-002 SHALL have port clk_i, input, 1, the single clock.
REQ-003 SHALL have port reset_ni, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port src_valid_i, input, NUM_SRC, a per-source result-valid flag.
REQ-005 SHALL have port src_tag_i, input, NUM_SRC x rs_tag_t, the per-source producing reservation-station tag.
REQ-006 SHALL have port src_val_i, input, NUM_SRC x word32_t, the per-source result value.
REQ-007 SHALL have port src_spec_i, input, NUM_SRC, marking a result as produced under an unresolved branch.
REQ-008 SHALL have port src_ready_o, output, NUM_SRC, a per-source accept flag.
REQ-009 SHALL have port cond_eval_i, input, 1, meaning the branch ALU resolved a condition this cycle.
REQ-010 SHALL have port corr_pred_i, input, 1, meaning the prediction was correct; it is qualified by cond_eval_i.
REQ-011 SHALL have port cdb_o, output, cdb_t, the registered common data bus broadcast (tag, val).

Function
REQ-012 SHALL hold one result entry per source: valid, spec, tag, val.
REQ-013 SHALL drive src_ready_o[i] = ~entry_valid[i] | grant[i] combinationally, so a drained entry can be refilled in the same cycle.
REQ-014 SHALL capture a source result into its entry on the rising edge when src_valid_i[i] & src_ready_o[i].
REQ-015 SHALL accept and discard a source result whose tag equals NO_VAL, storing nothing.
REQ-016 SHALL grant at most one valid entry per cycle and register that entry into cdb_o at the next edge.
  - Minimum latency from source capture to appearance on cdb_o is 2 edges.
REQ-017 SHALL, in a cycle with no grant, load cdb_o.tag = NO_VAL and cdb_o.val = 0.
REQ-018 SHALL clear a granted entry's valid bit at the grant edge, unless it is refilled at the same edge.
REQ-019 SHALL, on cond_eval_i & ~corr_pred_i (squash):
  - invalidate every entry with spec=1 at that edge;
  - exclude those entries from the grant in that cycle;
  - accept and discard incoming results with src_spec_i=1 in that cycle.
REQ-020 SHALL, on cond_eval_i & corr_pred_i (commit):
  - clear all spec bits at that edge;
  - store incoming results in that cycle with spec=0.
REQ-021 SHALL NOT retract a broadcast already on cdb_o when a squash arrives.
REQ-022 SHALL, when all entries are invalid, keep cdb_o.tag = NO_VAL indefinitely.
REQ-023 SHALL let a source that is granted and presenting a new result in the same cycle refill its entry with no bubble.

Reset
REQ-024 SHALL, on reset_ni low, asynchronously clear all entry valid and spec bits.
REQ-025 SHALL, on reset_ni low, set cdb_o.tag = NO_VAL and cdb_o.val = 0.
REQ-026 SHALL, on reset_ni low, set the round-robin pointer to 0.
REQ-027 SHALL hold src_ready_o all-ones while in reset, since every entry is empty.
REQ-028 SHALL cause reset asserted mid-operation to drop all buffered results with no broadcast.

Configuration
REQ-029 SHALL, with CDB_RR_ARB_EN defined, use round-robin arbitration:
  - search starts at the pointer;
  - after each grant the pointer advances to (granted index + 1) mod NUM_SRC;
  - the pointer is unchanged when there is no grant.
REQ-030 SHALL, without CDB_RR_ARB_EN, use fixed priority with the lowest valid index winning, and have no pointer state.

Structure
REQ-031 SHALL take cdb_t, rs_tag_t, word32_t and NO_VAL from data_types, and SHALL add CDB_NUM_SRC to data_types.
REQ-032 SHALL implement arbitration in one sub-module, cdb_rr_arbiter (request vector in, one-hot grant out, pointer state under CDB_RR_ARB_EN).

Verification
REQ-033 SHALL cover single source: src 2 presents tag 5, val 0xDEADBEEF at cycle 0 -> cdb_o = {5, 0xDEADBEEF} after edge 2, then NO_VAL after edge 3.
REQ-034 SHALL cover contention:
  - stimulus: srcs 0-3 valid at the same cycle with tags 1-4;
  - with CDB_RR_ARB_EN -> tags 1, 2, 3, 4 on consecutive cycles;
  - then srcs 0 and 3 valid again -> tag 4 winner index 3 not repeated, order 1 then 4 per pointer = 0.
REQ-035 SHALL cover squash:
  - stimulus: entries 1 (spec, tag 7) and 2 (non-spec, tag 8) valid, then cond_eval_i=1, corr_pred_i=0;
  - required: tag 7 is never broadcast, tag 8 is broadcast.
REQ-036 SHALL cover commit: spec entry tag 9 then cond_eval_i=1, corr_pred_i=1 at the same cycle as a spec input tag 10 -> both broadcast, and a later squash drops neither.
REQ-037 SHALL cover backpressure and refill: src 0 valid every cycle with tags 1, 2, 3 and no other source -> src_ready_o[0] stays high and tags 1, 2, 3 are broadcast back-to-back.
REQ-038 SHALL cover reset: reset_ni pulsed low mid-stream with 3 entries full -> cdb_o.tag = NO_VAL immediately and no buffered tag appears afterward.
